// File: rtl/gpr_pkg.sv
// Shared constants and types for the GPR writeback scheduler.
package gpr_pkg;

  localparam int XLEN     = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;

  localparam logic [ADDR_W-1:0] X0_ADDR = '0;

  // Requester identity; also the bit index of each requester in grant vectors.
  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_LSU = 1'b1
  } req_id_e;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-requester round-robin arbiter; the pointer names the requester favoured on contention.
module rr_arbiter_2
  import gpr_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  req_id_e ptr_q, ptr_d;

  // The pointer only moves when both requesters contend; a lone requester is always served.
  always_comb begin
    gnt_o = '0;
    ptr_d = ptr_q;
    if (req_i[REQ_ALU] && req_i[REQ_LSU]) begin
      if (ptr_q == REQ_ALU) begin
        gnt_o[REQ_ALU] = 1'b1;
        ptr_d          = REQ_LSU;
      end else begin
        gnt_o[REQ_LSU] = 1'b1;
        ptr_d          = REQ_ALU;
      end
    end else begin
      gnt_o = req_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= REQ_ALU;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/gpr_wb_scheduler.sv
// Serialises ALU/LSU writebacks onto the single register-file write port and
// tracks pending destinations in a busy scoreboard that stalls issue on hazards.
module gpr_wb_scheduler
  import gpr_pkg::*;
(
  input  logic                clock_in,
  input  logic                reset_in,
  input  logic                issue_valid_in,
  input  logic [ADDR_W-1:0]   issue_rs1_addr_in,
  input  logic [ADDR_W-1:0]   issue_rs2_addr_in,
  input  logic [ADDR_W-1:0]   issue_rd_addr_in,
  output logic                issue_stall_out,
  input  logic                alu_wb_valid_in,
  input  logic [ADDR_W-1:0]   alu_wb_addr_in,
  input  logic [XLEN-1:0]     alu_wb_data_in,
  output logic                alu_wb_ready_out,
  input  logic                lsu_wb_valid_in,
  input  logic [ADDR_W-1:0]   lsu_wb_addr_in,
  input  logic [XLEN-1:0]     lsu_wb_data_in,
  output logic                lsu_wb_ready_out,
  output logic                rd_we_out,
  output logic [ADDR_W-1:0]   rd_addr_out,
  output logic [XLEN-1:0]     rd_data_out,
  output logic [NUM_REGS-1:0] busy_out,
  output logic                wb_err_out
);

  // Handshake: a writeback transfers in any cycle where valid && ready; ready is
  // combinational from both valids and the arbiter pointer, and a requester that
  // is not granted must hold valid, addr and data stable until it is.

  logic [1:0]          req, gnt;
  logic                xfer_valid, xfer_live, issue_fire;
  logic [ADDR_W-1:0]   xfer_addr;
  logic [XLEN-1:0]     xfer_data;

  logic                rd_we_q, rd_we_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic [XLEN-1:0]     rd_data_q, rd_data_d;
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic                err_q, err_d;

  assign req[REQ_ALU] = alu_wb_valid_in;
  assign req[REQ_LSU] = lsu_wb_valid_in;

  rr_arbiter_2 u_arb (
    .clk_i  (clock_in),
    .rst_ni (reset_in),
    .req_i  (req),
    .gnt_o  (gnt)
  );

  assign alu_wb_ready_out = gnt[REQ_ALU];
  assign lsu_wb_ready_out = gnt[REQ_LSU];

  assign xfer_valid = |gnt;
  assign xfer_addr  = gnt[REQ_LSU] ? lsu_wb_addr_in : alu_wb_addr_in;
  assign xfer_data  = gnt[REQ_LSU] ? lsu_wb_data_in : alu_wb_data_in;
  // Writes to x0 are consumed here and never reach the register file.
  assign xfer_live  = xfer_valid && (xfer_addr != X0_ADDR);

  assign issue_stall_out = issue_valid_in &&
                           (busy_q[issue_rs1_addr_in] ||
                            busy_q[issue_rs2_addr_in] ||
                            busy_q[issue_rd_addr_in]);

  assign issue_fire = issue_valid_in && !issue_stall_out &&
                      (issue_rd_addr_in != X0_ADDR);

  always_comb begin
    rd_we_d   = xfer_live;
    rd_addr_d = rd_addr_q;
    rd_data_d = rd_data_q;
    if (xfer_live) begin
      rd_addr_d = xfer_addr;
      rd_data_d = xfer_data;
    end
  end

  // Clear on the edge the register file captures the write; a same-edge set wins.
  always_comb begin
    busy_d = busy_q;
    if (rd_we_q) begin
      busy_d[rd_addr_q] = 1'b0;
    end
    if (issue_fire) begin
      busy_d[issue_rd_addr_in] = 1'b1;
    end
    busy_d[X0_ADDR] = 1'b0;
  end

  assign err_d = err_q || (xfer_live && !busy_q[xfer_addr]);

  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      rd_we_q   <= 1'b0;
      rd_addr_q <= '0;
      rd_data_q <= '0;
      busy_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      rd_we_q   <= rd_we_d;
      rd_addr_q <= rd_addr_d;
      rd_data_q <= rd_data_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
    end
  end

  assign rd_we_out   = rd_we_q;
  assign rd_addr_out = rd_addr_q;
  assign rd_data_out = rd_data_q;
  assign busy_out    = busy_q;
  assign wb_err_out  = err_q;

endmodule

// File: tb/tb_gpr_wb_scheduler.sv
// Directed bench for gpr_wb_scheduler: scoreboard of register-file writes plus
// step-by-step checks of handshake, stall, scoreboard and error behaviour.
module tb_gpr_wb_scheduler;
  import gpr_pkg::*;

  logic                clk;
  logic                rst_n;
  logic                issue_valid;
  logic [ADDR_W-1:0]   issue_rs1, issue_rs2, issue_rd;
  logic                issue_stall;
  logic                alu_valid;
  logic [ADDR_W-1:0]   alu_addr;
  logic [XLEN-1:0]     alu_data;
  logic                alu_ready;
  logic                lsu_valid;
  logic [ADDR_W-1:0]   lsu_addr;
  logic [XLEN-1:0]     lsu_data;
  logic                lsu_ready;
  logic                rd_we;
  logic [ADDR_W-1:0]   rd_addr;
  logic [XLEN-1:0]     rd_data;
  logic [NUM_REGS-1:0] busy;
  logic                wb_err;

  localparam int EW = ADDR_W + XLEN;

  logic [EW-1:0] exp_q[$];
  int tests_run    = 0;
  int tests_failed = 0;

  gpr_wb_scheduler dut (
    .clock_in          (clk),
    .reset_in          (rst_n),
    .issue_valid_in    (issue_valid),
    .issue_rs1_addr_in (issue_rs1),
    .issue_rs2_addr_in (issue_rs2),
    .issue_rd_addr_in  (issue_rd),
    .issue_stall_out   (issue_stall),
    .alu_wb_valid_in   (alu_valid),
    .alu_wb_addr_in    (alu_addr),
    .alu_wb_data_in    (alu_data),
    .alu_wb_ready_out  (alu_ready),
    .lsu_wb_valid_in   (lsu_valid),
    .lsu_wb_addr_in    (lsu_addr),
    .lsu_wb_data_in    (lsu_data),
    .lsu_wb_ready_out  (lsu_ready),
    .rd_we_out         (rd_we),
    .rd_addr_out       (rd_addr),
    .rd_data_out       (rd_data),
    .busy_out          (busy),
    .wb_err_out        (wb_err)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [ADDR_W-1:0] a, input logic [XLEN-1:0] d);
    exp_q.push_back({a, d});
  endtask

  // Driver tasks
  task automatic issue_drive(input logic [ADDR_W-1:0] rs1, rs2, rd);
    issue_valid = 1'b1;
    issue_rs1   = rs1;
    issue_rs2   = rs2;
    issue_rd    = rd;
  endtask

  task automatic issue_idle();
    issue_valid = 1'b0;
    issue_rs1   = '0;
    issue_rs2   = '0;
    issue_rd    = '0;
  endtask

  task automatic alu_drive(input logic v, input logic [ADDR_W-1:0] a, input logic [XLEN-1:0] d);
    alu_valid = v;
    alu_addr  = a;
    alu_data  = d;
  endtask

  task automatic lsu_drive(input logic v, input logic [ADDR_W-1:0] a, input logic [XLEN-1:0] d);
    lsu_valid = v;
    lsu_addr  = a;
    lsu_data  = d;
  endtask

  // Scoreboard: every register-file write must match the oldest expected entry
  always @(negedge clk) begin
    if (rst_n && rd_we) begin
      logic pending;
      logic [EW-1:0] e;
      pending = (exp_q.size() != 0);
      check("wr_expected", {63'd0, pending}, 64'd1);
      if (pending) begin
        e = exp_q.pop_front();
        check("wr_addr_data", {27'd0, rd_addr, rd_data}, {27'd0, e});
      end
    end
  end

  initial begin
    logic [XLEN-1:0] da, db, dc, dd, de;
    da = $urandom_range(32'h7fff_ffff, 1);
    db = $urandom_range(32'h7fff_ffff, 1);
    dc = $urandom_range(32'h7fff_ffff, 1);
    dd = $urandom_range(32'h7fff_ffff, 1);
    de = $urandom_range(32'h7fff_ffff, 1);

    rst_n = 1'b0;
    issue_idle();
    alu_drive(1'b0, '0, '0);
    lsu_drive(1'b0, '0, '0);
    #3;
    check("rst_busy",  busy,   64'd0);
    check("rst_we",    rd_we,  64'd0);
    check("rst_addr",  rd_addr, 64'd0);
    check("rst_data",  rd_data, 64'd0);
    check("rst_err",   wb_err, 64'd0);
    check("rst_stall", issue_stall, 64'd0);
    tick();
    tick();
    rst_n = 1'b1;

    // Issue rd=x5, then ALU writes x5 while a dependent instruction stalls
    issue_drive(5'd0, 5'd0, 5'd5);
    #1 check("issue5_stall", issue_stall, 64'd0);
    tick();
    check("busy_x5", busy, 64'h20);
    issue_drive(5'd5, 5'd0, 5'd6);
    alu_drive(1'b1, 5'd5, 32'hDEADBEEF);
    #1;
    check("raw_stall_n", issue_stall, 64'd1);
    check("alu_ready_x5", alu_ready, 64'd1);
    push_exp(5'd5, 32'hDEADBEEF);
    tick();
    alu_drive(1'b0, '0, '0);
    #1;
    check("we_n1", rd_we, 64'd1);
    check("addr_n1", rd_addr, 64'd5);
    check("stall_n1", issue_stall, 64'd1);
    check("busy_n1", busy, 64'h20);
    tick();
    check("busy_n2", busy, 64'd0);
    check("stall_n2", issue_stall, 64'd0);
    check("we_n2", rd_we, 64'd0);
    tick();
    issue_idle();
    check("busy_x6_only", busy, 64'h40);

    // Contention: ALU and LSU both valid, pointer alternates
    issue_drive(5'd0, 5'd0, 5'd3); tick();
    issue_drive(5'd0, 5'd0, 5'd4); tick();
    issue_drive(5'd0, 5'd0, 5'd8); tick();
    issue_idle();
    check("busy_pre_rr", busy, 64'h158);
    alu_drive(1'b1, 5'd3, da);
    lsu_drive(1'b1, 5'd4, db);
    #1;
    check("rr1_alu", alu_ready, 64'd1);
    check("rr1_lsu", lsu_ready, 64'd0);
    push_exp(5'd3, da);
    tick();
    alu_drive(1'b1, 5'd8, dc);
    #1;
    check("rr2_alu", alu_ready, 64'd0);
    check("rr2_lsu", lsu_ready, 64'd1);
    check("rr2_we", rd_we, 64'd1);
    push_exp(5'd4, db);
    tick();
    lsu_drive(1'b1, 5'd6, dd);
    #1;
    check("rr3_alu", alu_ready, 64'd1);
    check("rr3_lsu", lsu_ready, 64'd0);
    check("rr3_we", rd_we, 64'd1);
    push_exp(5'd8, dc);
    tick();
    alu_drive(1'b0, '0, '0);
    #1;
    check("rr4_lsu", lsu_ready, 64'd1);
    check("rr4_we", rd_we, 64'd1);
    push_exp(5'd6, dd);
    tick();
    lsu_drive(1'b0, '0, '0);
    check("rr5_we", rd_we, 64'd1);
    check("rr5_addr", rd_addr, 64'd6);
    tick();
    check("rr_busy_clear", busy, 64'd0);
    check("rr_err", wb_err, 64'd0);

    // LSU write to x0: accepted, never reaches the register file
    lsu_drive(1'b1, 5'd0, 32'h1);
    #1 check("x0_ready", lsu_ready, 64'd1);
    tick();
    lsu_drive(1'b0, '0, '0);
    check("x0_we", rd_we, 64'd0);
    check("x0_busy", busy, 64'd0);
    check("x0_err", wb_err, 64'd0);
    tick();
    check("x0_we2", rd_we, 64'd0);

    // ALU write to non-busy x7 raises the sticky error but still writes
    alu_drive(1'b1, 5'd7, de);
    push_exp(5'd7, de);
    tick();
    alu_drive(1'b0, '0, '0);
    check("err_set", wb_err, 64'd1);
    check("err_we", rd_we, 64'd1);
    check("err_addr", rd_addr, 64'd7);
    tick();
    tick();
    check("err_sticky", wb_err, 64'd1);
    check("err_we_off", rd_we, 64'd0);

    // Reset in the cycle after an accepted transfer drops the held write
    issue_drive(5'd0, 5'd0, 5'd9);
    tick();
    issue_idle();
    check("busy_x9", busy, 64'h200);
    alu_drive(1'b1, 5'd9, 32'h0BAD_F00D);
    tick();
    alu_drive(1'b0, '0, '0);
    check("pre_rst_we", rd_we, 64'd1);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("mid_rst_we", rd_we, 64'd0);
    check("mid_rst_busy", busy, 64'd0);
    check("mid_rst_err", wb_err, 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_we", rd_we, 64'd0);
    tick();

    check("queue_drained", exp_q.size(), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Watchdog
  initial begin
    #20000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/gpr_wb_scheduler.md
Name: gpr_wb_scheduler

Overview:
- Sequences all writes into the general purpose register file, which has a single rd write port.
- Arbitrates round-robin between the ALU and LSU writeback requesters.
- Registers the winning write and drives the register file's rd port one cycle later.
- Keeps a 32-bit busy scoreboard of pending destinations and stalls issue on RAW/WAW hazards.

Parameters:
- XLEN, 32, data width of a register.
- ADDR_W, 5, register address width.
- NUM_REGS, 32, number of integer registers; x0 is hardwired zero.

Ports:
- clock_in  in  1  single clock; all state updates on the rising edge.
- reset_in  in  1  asynchronous, active-low reset.
- issue_valid_in  in  1  decode presents an instruction.
- issue_rs1_addr_in  in  ADDR_W  source 1 address.
- issue_rs2_addr_in  in  ADDR_W  source 2 address.
- issue_rd_addr_in  in  ADDR_W  destination address.
- issue_stall_out  out  1  hazard; decode must hold.
- alu_wb_valid_in  in  1  ALU result available.
- alu_wb_addr_in  in  ADDR_W  ALU destination.
- alu_wb_data_in  in  XLEN  ALU result.
- alu_wb_ready_out  out  1  ALU write accepted this cycle.
- lsu_wb_valid_in  in  1  load data available.
- lsu_wb_addr_in  in  ADDR_W  load destination.
- lsu_wb_data_in  in  XLEN  load data.
- lsu_wb_ready_out  out  1  LSU write accepted this cycle.
- rd_we_out  out  1  register file write enable.
- rd_addr_out  out  ADDR_W  register file write address.
- rd_data_out  out  XLEN  register file write data.
- busy_out  out  NUM_REGS  scoreboard; bit i = write to xi pending.
- wb_err_out  out  1  sticky: writeback targeted a non-busy, nonzero register.

Behaviour:
Reset (reset_in=0, asynchronous, takes effect immediately):
- busy=0, rd_we_out=0, rd_addr_out=0, rd_data_out=0, wb_err_out=0.
- Round-robin pointer set to favour ALU.
- A write held in the output register is dropped.

Arbitration:
- At most one grant per cycle. ready_out is combinational from the valid inputs and the pointer.
- Only one requester valid: that requester is granted.
- Both valid: the pointer's favoured requester is granted, and the pointer flips to the other.
- A transfer occurs when valid && ready. A requester not granted holds valid, addr and data stable.

Output stage:
- A transfer in cycle N drives rd_we_out=1 with rd_addr_out/rd_data_out in cycle N+1, for one cycle. Latency is 1.
- A back-to-back transfer gives rd_we_out high on consecutive cycles.
- A transfer with addr=0 is accepted, but rd_we_out stays 0 and the scoreboard and wb_err_out are unaffected.

Scoreboard:
- Set: when issue_valid_in && !issue_stall_out && issue_rd_addr_in!=0, busy[rd] is set at the edge.
- Clear: busy[rd_addr_out] is cleared at the edge ending a cycle with rd_we_out=1. This is when the register file captures the data, so a read in the next cycle sees the new value.
- Error: if a transfer targets a nonzero address whose busy bit is 0 at acceptance, wb_err_out is set. It is cleared only by reset. The write is still performed.
- Simultaneous set and clear of the same bit: set wins. This cannot occur legally, since busy[rd] stalls issue.
- busy[0] is constant 0.

Stall:
- issue_stall_out = issue_valid_in && (busy[rs1] || busy[rs2] || busy[rd]). It is combinational from the current busy state.
- There is no forwarding; the stall persists until the clear edge.

Decomposition:
- Shared package gpr_pkg: XLEN, ADDR_W, NUM_REGS, X0_ADDR constant, and a requester-ID enum (REQ_ALU, REQ_LSU) used for the pointer.
- One sub-module, rr_arbiter_2: a two-requester round-robin arbiter with a pointer flop, producing grant vectors. The scoreboard and output register live in the top module.

Test Plan:
- Reset then issue rd=x5 → busy_out=0x00000020. ALU writes x5=0xDEADBEEF, accepted in cycle N → rd_we_out=1, addr=5, data=0xDEADBEEF in N+1; busy_out=0 in N+2.
- x5 busy, issue rs1=x5 → issue_stall_out=1 until the cycle after rd_we_out for x5, then 0; busy[x5] re-set only if issue rd=x5 proceeds.
- ALU (x3) and LSU (x4) valid together for 2 cycles after reset → ALU granted first, then LSU. rd_we_out high 2 consecutive cycles, addr 3 then 4. Pointer then favours ALU.
- LSU writeback to x0 with data 0x1 → lsu_wb_ready_out=1; rd_we_out stays 0; busy_out and wb_err_out unchanged.
- ALU writeback to x7 with busy[7]=0 → wb_err_out=1 and sticky; rd_we_out pulses for x7.
- reset_in driven low in the cycle after an accepted transfer → rd_we_out=0 immediately, busy_out=0; no write to the register file occurs.
